// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB full-speed receive control path.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        RCV,
        STORE,
        EOP_WAIT,
        ERR_WAIT,
        ERR_EIDLE
    } rx_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'h80;
    localparam int         MAX_DEFAULT  = 64;

    // States in which a packet is considered in progress on the line.
    function automatic logic state_is_rcving(rx_state_t s);
        return (s == SYNC) || (s == RCV) || (s == STORE) ||
               (s == EOP_WAIT) || (s == ERR_WAIT);
    endfunction

endpackage

// File: rtl/usb_rx_bit_counter.sv
// 3-bit bit-position counter within the current byte; wraps 7->0, clear wins over enable.
module usb_rx_bit_counter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] bit_cnt
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= 3'd0;
        end else if (clear) begin
            bit_cnt <= 3'd0;
        end else if (enable) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control FSM: SYNC check, FIFO write strobes, packet end classification.
// Optional macro USB_RX_BYTE_COUNT_EN adds pkt_bytes/pkt_done good-packet reporting.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int         MAX_BYTES = MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error,
`ifdef USB_RX_BYTE_COUNT_EN
    output logic [6:0] pkt_bytes,
    output logic       pkt_done,
`endif
    output logic [2:0] state_dbg
);

    // Handshake: w_enable is a one-cycle strobe; the FIFO must capture rcv_data
    // in that cycle, there is no ready/backpressure path.

    rx_state_t  state;
    rx_state_t  next_state;
    logic [2:0] bit_cnt;
    logic [6:0] byte_cnt;
    logic       bit_clear;
    logic       bit_en;
    logic       set_err;
    logic       clr_err;
    logic       overflow;
    logic       eop_sample;

    assign eop_sample = eop && shift_enable;
    assign overflow   = (int'(byte_cnt) + 1) > MAX_BYTES;
    assign state_dbg  = state;

    // A new byte window starts on entry to RCV or whenever a byte completes.
    assign bit_clear = byte_received || ((next_state == RCV) && (state != RCV));
    assign bit_en    = (state == RCV) && shift_enable && !eop;

    usb_rx_bit_counter u_bit_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (bit_clear),
        .enable  (bit_en),
        .bit_cnt (bit_cnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        case (state)
            IDLE: begin
                if (d_edge) begin
                    next_state = SYNC;
                    clr_err    = 1'b1;
                end
            end
            SYNC: begin
                if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) begin
                        next_state = RCV;
                    end else begin
                        next_state = ERR_WAIT;
                        set_err    = 1'b1;
                    end
                end else if (eop_sample) begin
                    next_state = ERR_EIDLE;
                    set_err    = 1'b1;
                end
            end
            RCV: begin
                // A completed byte takes priority; a coincident EOP is seen again later.
                if (byte_received) begin
                    next_state = STORE;
                end else if (eop_sample) begin
                    if (bit_cnt == 3'd0) begin
                        next_state = EOP_WAIT;
                    end else begin
                        next_state = ERR_EIDLE;
                        set_err    = 1'b1;
                    end
                end
            end
            STORE: begin
                if (overflow) begin
                    next_state = ERR_WAIT;
                    set_err    = 1'b1;
                end else begin
                    next_state = RCV;
                end
            end
            EOP_WAIT: begin
                if (d_edge) next_state = IDLE;
            end
            ERR_WAIT: begin
                if (eop_sample) next_state = ERR_EIDLE;
            end
            ERR_EIDLE: begin
                if (d_edge) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are flops decoded from the current state, one cycle behind it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rcving   <= 1'b0;
            w_enable <= 1'b0;
        end else begin
            rcving   <= state_is_rcving(state);
            w_enable <= (state == STORE) && !overflow;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_error <= 1'b0;
        end else if (clr_err) begin
            r_error <= 1'b0;
        end else if (set_err) begin
            r_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt <= 7'd0;
        end else if (state == IDLE) begin
            byte_cnt <= 7'd0;
        end else if (w_enable) begin
            byte_cnt <= byte_cnt + 7'd1;
        end
    end

`ifdef USB_RX_BYTE_COUNT_EN
    logic good_end;
    assign good_end = (state == RCV) && (next_state == EOP_WAIT);

    // Include a write landing in the same cycle as the EOP sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_bytes <= 7'd0;
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= good_end;
            if (good_end) begin
                pkt_bytes <= byte_cnt + {6'd0, w_enable};
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl with a write-data scoreboard and per-step state checks.
module tb_usb_rx_ctrl;
    import usb_rx_pkg::*;

    logic       clk;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [2:0] state_dbg;
`ifdef USB_RX_BYTE_COUNT_EN
    logic [6:0] pkt_bytes;
    logic       pkt_done;
    int         done_cnt = 0;
`endif

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_br = 0;
    int         wen_cnt = 0;
    int         wen_mark;
    logic [7:0] exp_q[$];

    usb_rx_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(4)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
`ifdef USB_RX_BYTE_COUNT_EN
        .pkt_bytes     (pkt_bytes),
        .pkt_done      (pkt_done),
`endif
        .state_dbg     (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick(input logic de, input logic se, input logic ee, input logic br);
        d_edge        = de;
        shift_enable  = se;
        eop           = ee;
        byte_received = br;
        @(posedge clk);
        #1;
        d_edge        = 1'b0;
        shift_enable  = 1'b0;
        eop           = 1'b0;
        byte_received = 1'b0;
    endtask

    task automatic shifts(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic wr);
        shifts(8);
        rcv_data = b;
        if (wr) exp_q.push_back(b);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic eop_strobe();
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic end_edge();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every write strobe pops one expected byte.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        cyc++;
        if (byte_received === 1'b1) last_br = cyc;
        if (w_enable === 1'b1) begin
            wen_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wen: got data %0h expected no write", rcv_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("wen_data", rcv_data, exp_b);
                check("wen_latency", cyc - last_br, 2);
            end
        end
`ifdef USB_RX_BYTE_COUNT_EN
        if (pkt_done === 1'b1) done_cnt++;
`endif
    end

    initial begin
        n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
        byte_received = 1'b0; rcv_data = 8'h00;
        #22;
        check("reset_rcving", rcving, 0);
        check("reset_wen", w_enable, 0);
        check("reset_rerr", r_error, 0);
        check("reset_state", state_dbg, IDLE);
        n_rst = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Good 2-byte packet
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("good_state_sync", state_dbg, SYNC);
        send_byte(8'h80, 1'b0);
        check("good_state_rcv", state_dbg, RCV);
        check("good_rcving", rcving, 1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        eop_strobe();
        check("good_state_eopw", state_dbg, EOP_WAIT);
        check("good_rcving_eop", rcving, 1);
        check("good_rerr", r_error, 0);
        end_edge();
        check("good_state_idle", state_dbg, IDLE);
        check("good_rcving_end", rcving, 0);
        check("good_wen_cnt", wen_cnt, 2);
`ifdef USB_RX_BYTE_COUNT_EN
        check("good_pkt_bytes", pkt_bytes, 2);
        check("good_pkt_done", done_cnt, 1);
`endif

        // Bad SYNC, trailing bytes ignored, error survives the return to IDLE
        wen_mark = wen_cnt;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h81, 1'b0);
        check("badsync_state", state_dbg, ERR_WAIT);
        check("badsync_rerr", r_error, 1);
        send_byte(8'h55, 1'b0);
        eop_strobe();
        check("badsync_state_eidle", state_dbg, ERR_EIDLE);
        end_edge();
        check("badsync_state_idle", state_dbg, IDLE);
        check("badsync_rerr_idle", r_error, 1);
        check("badsync_no_wen", wen_cnt - wen_mark, 0);

        // Next good 1-byte packet clears the error at its start
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("clear_rerr", r_error, 0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h5A, 1'b1);
        eop_strobe();
        end_edge();
        check("one_rerr", r_error, 0);
`ifdef USB_RX_BYTE_COUNT_EN
        check("one_pkt_bytes", pkt_bytes, 1);
`endif

        // Partial-byte EOP
        wen_mark = wen_cnt;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h11, 1'b1);
        shifts(3);
        eop_strobe();
        check("partial_state", state_dbg, ERR_EIDLE);
        check("partial_rerr", r_error, 1);
        check("partial_rcving", rcving, 0);
        check("partial_wen", wen_cnt - wen_mark, 1);
        end_edge();
`ifdef USB_RX_BYTE_COUNT_EN
        check("partial_pkt_bytes_hold", pkt_bytes, 1);
`endif

        // Overflow with MAX_BYTES=4
        wen_mark = wen_cnt;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check("ovf_rerr_before", r_error, 0);
        send_byte(8'h05, 1'b0);
        check("ovf_state", state_dbg, ERR_WAIT);
        check("ovf_rerr", r_error, 1);
        check("ovf_wen", wen_cnt - wen_mark, 4);
        eop_strobe();
        end_edge();

        // Early EOP while waiting for SYNC
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("early_rcving_on", rcving, 1);
        check("early_rerr_clr", r_error, 0);
        eop_strobe();
        check("early_state", state_dbg, ERR_EIDLE);
        check("early_rerr", r_error, 1);
        check("early_rcving_off", rcving, 0);
        end_edge();

        // Asynchronous reset in the middle of the second byte
        wen_mark = wen_cnt;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h22, 1'b1);
        shifts(4);
        #2 n_rst = 1'b0;
        #1;
        check("arst_rcving", rcving, 0);
        check("arst_wen", w_enable, 0);
        check("arst_rerr", r_error, 0);
        check("arst_state", state_dbg, IDLE);
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
        #2 n_rst = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("arst_wen_total", wen_cnt - wen_mark, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        eop_strobe();
        check("after_rst_state", state_dbg, EOP_WAIT);
        check("after_rst_rerr", r_error, 0);
        end_edge();
`ifdef USB_RX_BYTE_COUNT_EN
        check("after_rst_pkt_bytes", pkt_bytes, 2);
        check("total_pkt_done", done_cnt, 3);
`endif

        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("total_wen", wen_cnt, 11);
        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
- Receive-side control FSM for the USB full-speed receiver datapath.
- Consumes line-event strobes (edge detect, EOP detect from the SE0 detector, shift-enable timing) and the shifted byte.
- Validates the SYNC byte, issues one-cycle FIFO write enables per data byte, and classifies packet termination as good or error.
- Sits between the bit-level datapath (edge/EOP detectors, shift register, timer) and the RX FIFO.

Parameters:
- SYNC_BYTE, 8'h80, required first byte after the packet starts (LSB-first shifted value).
- MAX_BYTES, 64, maximum data bytes per packet after SYNC; exceeding it is an error.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- d_edge  in  1  one-cycle strobe on any D+/D- transition
- eop  in  1  level, high while the line is SE0 (D+ and D- both low)
- shift_enable  in  1  one-cycle strobe at each bit sample point
- byte_received  in  1  one-cycle strobe when 8 bits have been shifted
- rcv_data  in  8  current shift register contents
- rcving  out  1  high while a packet is in progress
- w_enable  out  1  one-cycle FIFO write strobe
- r_error  out  1  sticky packet-error flag

Behaviour:
- Reset (async, n_rst=0): state IDLE; rcving=0, w_enable=0, r_error=0; bit_cnt=0; byte_cnt=0. All outputs are registered and Moore-decoded from the state, except r_error, which is a separate flop.
- bit_cnt (3-bit): cleared on entry to RCV. In RCV it increments on shift_enable&&!eop and wraps 7->0. It is also cleared in the cycle byte_received is seen.
- byte_cnt (7-bit): cleared in IDLE and increments on every w_enable.
- IDLE: d_edge -> SYNC; r_error cleared in the same cycle; rcving=1 from the next cycle.
- SYNC:
  - byte_received and rcv_data==SYNC_BYTE -> RCV.
  - byte_received with a mismatch -> ERR_WAIT, r_error set.
  - eop&&shift_enable before byte_received -> ERR_EIDLE, r_error set.
- RCV:
  - byte_received -> STORE.
  - eop&&shift_enable with bit_cnt==0 -> EOP_WAIT (good end).
  - eop&&shift_enable with bit_cnt!=0 -> ERR_EIDLE, r_error set (partial byte).
  - If byte_received and eop&&shift_enable occur in the same cycle, byte_received wins; the EOP is re-evaluated on its next shift_enable.
- STORE: w_enable=1 for exactly one cycle.
  - If byte_cnt+1 > MAX_BYTES: the write is suppressed, state -> ERR_WAIT, r_error set.
  - Otherwise state -> RCV.
- EOP_WAIT: rcving=1; d_edge (SE0 -> J) -> IDLE, rcving=0 the next cycle.
- ERR_WAIT: discard bytes (no w_enable); eop&&shift_enable -> ERR_EIDLE.
- ERR_EIDLE: rcving=0; d_edge -> IDLE, leaving r_error still set.
- r_error persistence: holds until the next packet start (IDLE with d_edge) or reset.
- Latency: w_enable asserts 2 cycles after the byte_received strobe (state registered, then STORE output).
- Reset mid-packet: immediate return to IDLE with all outputs low; no spurious w_enable.

Optional Feature:
- Macro: USB_RX_BYTE_COUNT_EN.
- Defined:
  - Extra output pkt_bytes[6:0], latched from byte_cnt on entry to EOP_WAIT (good packets only).
  - Extra output pkt_done, a one-cycle strobe on that same entry.
  - Both reset to 0; pkt_bytes holds until the next good packet.
- Undefined: neither port exists. byte_cnt is still used for the MAX_BYTES check.

Decomposition:
- Package usb_rx_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, SYNC, RCV, STORE, EOP_WAIT, ERR_WAIT, ERR_EIDLE}.
  - Localparam SYNC_DEFAULT=8'h80.
- Sub-module: usb_rx_bit_counter, holding bit_cnt with clear/enable/wrap. The FSM and byte_cnt stay in the top module.

Test Plan:
- Good 2-byte packet: d_edge; SYNC 8'h80; bytes 8'hA5, 8'h3C; then eop with shift_enable at bit_cnt=0; then d_edge.
  - Expect rcving high throughout.
  - Expect w_enable pulsed exactly twice, each 2 cycles after byte_received.
  - Expect r_error=0 and a return to IDLE.
  - With USB_RX_BYTE_COUNT_EN defined: pkt_bytes=2 and one pkt_done pulse.
- Bad SYNC: first byte 8'h81.
  - Expect r_error=1 and no w_enable.
  - Following bytes are ignored until EOP; r_error stays 1 after IDLE.
  - The next good packet's start clears r_error.
- Partial-byte EOP: SYNC, 1 byte, then 3 shift_enables, then eop&&shift_enable.
  - Expect exactly one w_enable, r_error=1, state ERR_EIDLE.
- Overflow with MAX_BYTES=4: SYNC plus 5 bytes.
  - Expect 4 w_enables, the 5th suppressed, r_error=1.
- Early EOP in SYNC: d_edge, then eop&&shift_enable before any byte.
  - Expect r_error=1 and rcving dropping to 0.
- Async reset: assert n_rst=0 mid-byte 2 of a packet, between clock edges.
  - Expect all outputs 0 immediately, no w_enable afterwards, and a clean receive of the next packet.
